// File: rtl/m_ack_pkg.sv
// -----------------------------------------------------------------------------
// m_ack_pkg
// Shared definitions for the m_ack_responder slice:
//   - state_e      : responder FSM state encoding
//   - GNT_*        : one-hot grant / acknowledge constants
//   - *_DEF        : default values for the responder parameters
// -----------------------------------------------------------------------------
package m_ack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_REQ = 2'd1,
        ST_DELAY    = 2'd2,
        ST_ACK      = 2'd3
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT0     = 2'b01;
    localparam logic [1:0] GNT1     = 2'b10;

    localparam int ACK_DLY_DEF = 2;
    localparam int TIMEOUT_DEF = 16;
    localparam int DATA_W_DEF  = 32;

endpackage

// File: rtl/m_ack_arb.sv
// -----------------------------------------------------------------------------
// m_ack_arb
// Two-requester arbiter producing a one-hot (or empty) grant.
// A lone requester always wins. On a tie the pointer decides: pointer=0 means
// bit 0 was the last winner (or nothing was granted yet), so bit 1 wins;
// pointer=1 means bit 1 won last, so bit 0 wins. Tying pointer to 0 gives
// fixed priority with req[1] over req[0].
// Ports:
//   req     in  [1:0] request lines
//   pointer in        index of the bit that lost priority (last winner)
//   grant   out [1:0] one-hot grant, GNT_NONE when req==0
// -----------------------------------------------------------------------------
module m_ack_arb
    import m_ack_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    // Combinational grant selection.
    always_comb begin
        grant = GNT_NONE;
        case (req)
            2'b01:   grant = GNT0;
            2'b10:   grant = GNT1;
            2'b11: begin
                if (pointer) begin
                    grant = GNT0;
                end else begin
                    grant = GNT1;
                end
            end
            default: grant = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/m_ack_responder_chk.sv
// -----------------------------------------------------------------------------
// m_ack_responder_chk
// Property checker for m_ack_responder outputs: ack one-hot or zero, ack
// implies not ready, err never high on two consecutive cycles.
// Ports: clk, rst, ready, ack[1:0], err (all inputs, observed only).
// -----------------------------------------------------------------------------
module m_ack_responder_chk (
    input logic       clk,
    input logic       rst,
    input logic       ready,
    input logic [1:0] ack,
    input logic       err
);

    a_ack_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(ack));

    a_ack_not_ready: assert property (@(posedge clk) disable iff (rst)
        (ack != 2'b00) |-> !ready);

    a_err_pulse: assert property (@(posedge clk) disable iff (rst)
        err |=> !err);

endmodule

// File: rtl/m_ack_responder.sv
// -----------------------------------------------------------------------------
// m_ack_responder
// Handshake responder: after a go in IDLE it waits for a request, arbitrates
// between the two requesters, captures the payload, and acknowledges the
// winner ACK_DLY cycles after the request was sampled. The ack is held until
// the granted request drops. A request-less wait of TIMEOUT edges aborts with
// a one-cycle err pulse. All outputs are registered.
//
// Build option: define M_ACK_RESPONDER_RR_EN for round-robin arbitration
// (pointer updated on ack completion); otherwise fixed priority req[1]>req[0].
//
// Parameters: ACK_DLY (1..15), TIMEOUT (2..255), DATA_W
// Ports:
//   clk     in               clock, rising edge
//   rst     in               synchronous active-high reset
//   go      in               transaction start (honoured only in IDLE)
//   req     in  [1:0]        independent request lines
//   data    in  [DATA_W-1:0] payload, captured on the grant edge
//   ready   out              1 in IDLE / WAIT_REQ
//   ack     out [1:0]        one-hot acknowledge
//   data_q  out [DATA_W-1:0] payload captured at grant
//   err     out              single-cycle timeout pulse
// -----------------------------------------------------------------------------
module m_ack_responder
    import m_ack_pkg::*;
#(
    parameter int ACK_DLY = ACK_DLY_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] data_q,
    output logic              err
);

    // Last timer value before abort: the TIMEOUT-th request-less edge.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    // DELAY occupies ACK_DLY-1 cycles; the counter runs down to zero.
    localparam logic [3:0] DLY_LOAD = (ACK_DLY > 1) ? 4'(ACK_DLY - 2) : 4'd0;

    state_e            state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic [3:0]        dly_q,   dly_d;
    logic [1:0]        gnt_q,   gnt_d;
    logic [1:0]        ack_q,   ack_d;
    logic              ready_q, ready_d;
    logic              err_q,   err_d;
    logic [DATA_W-1:0] data_d;
    logic [1:0]        grant_s;
    logic              arb_ptr_s;

`ifdef M_ACK_RESPONDER_RR_EN
    logic              ptr_q, ptr_d;
    assign arb_ptr_s = ptr_q;
`else
    assign arb_ptr_s = 1'b0;
`endif

    m_ack_arb u_arb (
        .req     (req),
        .pointer (arb_ptr_s),
        .grant   (grant_s)
    );

    // Next-state and next-output logic for the responder FSM.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dly_d   = dly_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        ready_d = ready_q;
        err_d   = 1'b0;
        data_d  = data_q;
`ifdef M_ACK_RESPONDER_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ack_d   = GNT_NONE;
                ready_d = 1'b1;
                // req is deliberately not looked at here, even alongside go.
                if (go) begin
                    state_d = ST_WAIT_REQ;
                    timer_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_REQ: begin
                if (req != 2'b00) begin
                    gnt_d   = grant_s;
                    data_d  = data;
                    dly_d   = DLY_LOAD;
                    ready_d = 1'b0;
                    timer_d = 8'd0;
                    if (ACK_DLY == 1) begin
                        state_d = ST_ACK;
                        ack_d   = grant_s;
                    end else begin
                        state_d = ST_DELAY;
                        ack_d   = GNT_NONE;
                    end
                end else if (timer_q >= TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    timer_d = 8'd0;
                end else begin
                    ready_d = 1'b1;
                    // Saturate rather than wrap.
                    if (timer_q == 8'hFF) begin
                        timer_d = timer_q;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end

            ST_DELAY: begin
                ready_d = 1'b0;
                if ((req & gnt_q) == 2'b00) begin
                    // Requester withdrew before ack: silent return.
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    ack_d   = GNT_NONE;
                    gnt_d   = GNT_NONE;
                    dly_d   = 4'd0;
                end else if (dly_q == 4'd0) begin
                    state_d = ST_ACK;
                    ack_d   = gnt_q;
                end else begin
                    dly_d   = dly_q - 4'd1;
                end
            end

            ST_ACK: begin
                if ((req & gnt_q) == 2'b00) begin
                    state_d = ST_IDLE;
                    ack_d   = GNT_NONE;
                    ready_d = 1'b1;
                    gnt_d   = GNT_NONE;
`ifdef M_ACK_RESPONDER_RR_EN
                    // Remember the winner so it loses the next tie.
                    ptr_d   = (gnt_q == GNT1);
`endif
                end else begin
                    ack_d   = gnt_q;
                    ready_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ack_d   = GNT_NONE;
                ready_d = 1'b1;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= 8'd0;
            dly_q   <= 4'd0;
            gnt_q   <= GNT_NONE;
            ack_q   <= GNT_NONE;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            data_q  <= '0;
`ifdef M_ACK_RESPONDER_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dly_q   <= dly_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            data_q  <= data_d;
`ifdef M_ACK_RESPONDER_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign ready = ready_q;
    assign ack   = ack_q;
    assign err   = err_q;

endmodule

// File: tb/tb_m_ack_responder.sv
module tb_m_ack_responder;

    localparam int ACK_DLY = 2;
    localparam int TIMEOUT = 16;
    localparam int DATA_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic [1:0]        req;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic [1:0]        ack;
    logic [DATA_W-1:0] data_q;
    logic              err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]        ack;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic       ptr_m = 1'b0;
    logic [1:0] last_ack;

    always #5 clk = ~clk;

    m_ack_responder #(
        .ACK_DLY (ACK_DLY),
        .TIMEOUT (TIMEOUT),
        .DATA_W  (DATA_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .req    (req),
        .data   (data),
        .ready  (ready),
        .ack    (ack),
        .data_q (data_q),
        .err    (err)
    );

    m_ack_responder_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .ack   (ack),
        .err   (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: lone requester wins; ties go against the last winner.
    function automatic logic [1:0] model_grant(input logic [1:0] r);
        if (r == 2'b11) begin
            return ptr_m ? 2'b01 : 2'b10;
        end
        return r;
    endfunction

    task automatic note_complete(input logic [1:0] g);
`ifdef M_ACK_RESPONDER_RR_EN
        ptr_m = (g == 2'b10);
`else
        ptr_m = 1'b0;
`endif
    endtask

    // go in IDLE, then present a request; expectation goes to the scoreboard.
    task automatic start(input logic [1:0] r, input logic [DATA_W-1:0] d);
        exp_t e;
        go = 1'b1;
        step();
        go   = 1'b0;
        req  = r;
        data = d;
        e.ack  = model_grant(r);
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input string tag);
        int   n = 0;
        exp_t e;
        while (ack == 2'b00 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(ACK_DLY));
        check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_ack"}, 64'(ack), 64'(e.ack));
            check({tag, "_data_q"}, 64'(data_q), 64'(e.data));
        end
        check({tag, "_ready_in_ack"}, 64'(ready), 64'(0));
        last_ack = ack;
    endtask

    task automatic complete(input string tag);
        req = req & ~last_ack;
        step();
        check({tag, "_ack_dropped"}, 64'(ack), 64'(0));
        check({tag, "_ready_after"}, 64'(ready), 64'(1));
        note_complete(last_ack);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        go   = 1'b0;
        req  = 2'b00;
        data = '0;
        step();
        step();
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_data_q", 64'(data_q), 64'(0));
        rst = 1'b0;
        step();
        check("idle_ready", 64'(ready), 64'(1));
        check("idle_ack", 64'(ack), 64'(0));

        // Basic transaction on req[1].
        start(2'b10, 32'hA5A5_0001);
        wait_ack("t1");
        go = 1'b1;                      // must be ignored in ACK
        step();
        go = 1'b0;
        check("t1_ack_held", 64'(ack), 64'(2'b10));
        check("t1_ready_held", 64'(ready), 64'(0));
        complete("t1");
        req = 2'b10;                    // request without go: no response
        step();
        step();
        step();
        check("idle_req_no_ack", 64'(ack), 64'(0));
        check("idle_req_ready", 64'(ready), 64'(1));
        check("idle_req_data_q", 64'(data_q), 64'(32'hA5A5_0001));
        req = 2'b00;

        // Reset clears the pointer, then back-to-back ties.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ptr_m = 1'b0;
        start(2'b11, 32'h0000_1111);
        wait_ack("t2");
        complete("t2");                 // leaves the losing request pending
        go = 1'b1;                      // go with a request high: request ignored
        step();
        check("go_req_same_edge_ack", 64'(ack), 64'(0));
        check("go_req_same_edge_data_q", 64'(data_q), 64'(32'h0000_1111));
        go = 1'b0;
        req = 2'b11;
        data = 32'h0000_2222;
        begin
            exp_t e;
            e.ack  = model_grant(2'b11);
            e.data = 32'h0000_2222;
            sb_q.push_back(e);
        end
        wait_ack("t3");
        complete("t3");
        req = 2'b00;
        step();
        start(2'b01, 32'h0000_3333);
        wait_ack("t4");
        complete("t4");
        req = 2'b00;

        // Timeout with no request.
        go = 1'b1;
        step();
        go = 1'b0;
        data = 32'hDEAD_BEEF;
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            check($sformatf("tmo_err_%0d", i), 64'(err), 64'(i == TIMEOUT));
        end
        check("tmo_ready", 64'(ready), 64'(1));
        check("tmo_ack", 64'(ack), 64'(0));
        check("tmo_data_q", 64'(data_q), 64'(32'h0000_3333));
        step();
        check("tmo_err_single", 64'(err), 64'(0));
        req = 2'b10;                    // back in IDLE: no response without go
        step();
        step();
        step();
        check("tmo_idle_ack", 64'(ack), 64'(0));
        req = 2'b00;

        // Request withdrawn during DELAY.
        go = 1'b1;
        step();
        go = 1'b0;
        req = 2'b01;
        data = 32'h1234_5678;
        step();
        check("dly_ready", 64'(ready), 64'(0));
        check("dly_data_q", 64'(data_q), 64'(32'h1234_5678));
        check("dly_ack", 64'(ack), 64'(0));
        req = 2'b00;
        step();
        check("drop_ack", 64'(ack), 64'(0));
        check("drop_err", 64'(err), 64'(0));
        check("drop_ready", 64'(ready), 64'(1));
        step();
        step();
        check("drop_ack_later", 64'(ack), 64'(0));
        check("drop_err_later", 64'(err), 64'(0));

        // Reset while acknowledging.
        start(2'b10, 32'h5555_AAAA);
        wait_ack("t5");
        rst = 1'b1;
        step();
        check("rst_ack_ack", 64'(ack), 64'(0));
        check("rst_ack_ready", 64'(ready), 64'(1));
        check("rst_ack_data_q", 64'(data_q), 64'(0));
        check("rst_ack_err", 64'(err), 64'(0));
        rst = 1'b0;
        req = 2'b00;
        ptr_m = 1'b0;
        step();
        check("post_rst_ack", 64'(ack), 64'(0));
        check("post_rst_ready", 64'(ready), 64'(1));

        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
